input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops (legal range 2..4).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the consecutive stable synchronized samples required to accept a change (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port d_i, input, 1 bit: raw asynchronous, possibly bouncing input level.
REQ-006 The block SHALL have port level_o, output, 1 bit: debounced registered level.
REQ-007 The block SHALL have port rise_o, output, 1 bit: one-cycle pulse on an accepted 0->1 change.
REQ-008 The block SHALL have port fall_o, output, 1 bit: one-cycle pulse on an accepted 1->0 change.
REQ-009 The block SHALL have port glitch_cnt_o, output, 8 bits: count of rejected transitions, saturating.

Function
REQ-010 d_i SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage output (sync) feeds the logic.
REQ-011 The FSM SHALL have exactly four states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-012 STABLE_LOW with sync=1 SHALL go to WAIT_HIGH and load the stability counter with 1; STABLE_HIGH with sync=0 SHALL go to WAIT_LOW and load 1.
REQ-013 In WAIT_x, when sync equals the candidate level, the counter SHALL increment each cycle.
REQ-014 When the counter reaches DEBOUNCE_CYCLES, the FSM SHALL enter STABLE_x on the next edge, with level_o updated on that same edge.
REQ-015 With DEBOUNCE_CYCLES=1, the WAIT state SHALL last exactly one cycle.
REQ-016 In WAIT_x, when sync reverts before the count completes, the FSM SHALL return to the previous STABLE state, clear the counter, and increment glitch_cnt_o.
REQ-017 glitch_cnt_o SHALL saturate at 255 and never wrap.
REQ-018 rise_o/fall_o SHALL be registered and high for exactly the one cycle in which level_o first shows its new value.
REQ-019 rise_o and fall_o SHALL never be high together.
REQ-020 For d_i held steady after a change, level_o SHALL change exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new d_i.
REQ-021 The stability counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never overflow.
REQ-022 The counter value and glitch_cnt_o SHALL be left unchanged in STABLE states with sync equal to level_o.

Reset
REQ-023 While rst_n=0, the block SHALL hold all synchronizer flops at 0, the FSM in STABLE_LOW, the counter at 0, level_o, rise_o and fall_o at 0, and glitch_cnt_o at 0.
REQ-024 rst_n assertion mid-debounce SHALL abort immediately with no pulse output and no glitch count.
REQ-025 When d_i=1 at reset release, the block SHALL be treated as a normal 0->1 change (rise_o pulses after the REQ-020 latency).

Structure
REQ-026 Package input_conditioner_pkg SHALL hold the state enum typedef (ic_state_t) and the glitch counter width/max constants.
REQ-027 The synchronizer chain SHALL be a sub-module bit_sync (parameter STAGES, ports clk, rst_n, d_i, q_o).
REQ-028 The FSM, counters and pulse registers SHALL live in input_conditioner; no latches, and a single always_ff per register group.

Verification
REQ-029 SYNC_STAGES=2, DEBOUNCE_CYCLES=4, reset then d_i 0->1 held -> level_o=1 and rise_o=1 for one cycle at the 6th edge; glitch_cnt_o=0.
REQ-030 Same config, d_i high for 2 cycles then low -> level_o stays 0, no pulses, glitch_cnt_o=1.
REQ-031 level_o=1, d_i 1->0 held -> fall_o single pulse 6 edges later, rise_o stays 0.
REQ-032 300 short glitches -> glitch_cnt_o=255 and held, level_o unchanged.
REQ-033 Assert rst_n=0 during WAIT_HIGH (counter=3), release with d_i=0 -> all outputs 0, no pulse at any later cycle.
REQ-034 DEBOUNCE_CYCLES=1, d_i=1 at reset release -> rise_o pulse at edge 3 after release, level_o=1 thereafter.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_conditioner_pkg
// Shared types and constants for the input conditioner.
//   ic_state_t   : debounce FSM state encoding
//   GLITCH_W     : width of the rejected-transition counter
//   GLITCH_MAX   : saturation value of the rejected-transition counter
//   glitch_inc() : saturating increment for the rejected-transition counter
// -----------------------------------------------------------------------------
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } ic_state_t;

  localparam int                  GLITCH_W   = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

  // Holds at GLITCH_MAX instead of wrapping back to zero.
  function automatic logic [GLITCH_W-1:0] glitch_inc(input logic [GLITCH_W-1:0] cnt);
    if (cnt == GLITCH_MAX) begin
      return cnt;
    end
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/input_conditioner_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d_i   : asynchronous input bit
//   q_o   : synchronized output (last stage of the chain)
// Parameter STAGES sets the chain depth (2..4).
// -----------------------------------------------------------------------------
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain;

  // chain[0] is the metastability-exposed flop; only chain[STAGES-1] leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Synchronizes and debounces a raw, possibly bouncing input level.
//   clk          : single clock, all state updates on its rising edge
//   rst_n        : asynchronous active-low reset
//   d_i          : raw asynchronous input level
//   level_o      : debounced registered level
//   rise_o       : one-cycle pulse when level_o first shows an accepted 0->1
//   fall_o       : one-cycle pulse when level_o first shows an accepted 1->0
//   glitch_cnt_o : saturating count of rejected transitions
//   state_o      : current debounce FSM state (debug visibility)
// Parameters:
//   SYNC_STAGES     : synchronizer depth (2..4)
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples needed (1..65535)
//
// Latency: with d_i held after a change, level_o moves exactly
// SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that
// samples the new d_i.
//
// Handshake: none; the block is a free-running level filter with no
// valid/ready interface.
// -----------------------------------------------------------------------------
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                d_i,
  output logic                level_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o,
  output ic_state_t           state_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // The counter holds the number of matching samples already seen. The
  // sample that would bring it to DEBOUNCE_CYCLES is accepted directly, so
  // the stored value never exceeds DEBOUNCE_CYCLES-1 and cannot overflow.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync;
  ic_state_t        state;
  logic [CNT_W-1:0] cnt;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (d_i),
    .q_o   (sync)
  );

  // FSM, stability counter, glitch counter, level and edge pulses.
  // The first differing sample seen in a STABLE state counts as sample 1.
  // With DEBOUNCE_CYCLES=1 that single sample is the whole qualification
  // window: the cycle in which sync first shows the new value is the one
  // waiting cycle, and the level is accepted on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= STABLE_LOW;
      cnt          <= '0;
      level_o      <= 1'b0;
      rise_o       <= 1'b0;
      fall_o       <= 1'b0;
      glitch_cnt_o <= '0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state   <= STABLE_HIGH;
              cnt     <= '0;
              level_o <= 1'b1;
              rise_o  <= 1'b1;
            end else begin
              state <= WAIT_HIGH;
              cnt   <= CNT_ONE;
            end
          end
        end

        WAIT_HIGH: begin
          if (sync) begin
            if (cnt == CNT_LAST) begin
              state   <= STABLE_HIGH;
              cnt     <= '0;
              level_o <= 1'b1;
              rise_o  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            state        <= STABLE_LOW;
            cnt          <= '0;
            glitch_cnt_o <= glitch_inc(glitch_cnt_o);
          end
        end

        STABLE_HIGH: begin
          if (!sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state   <= STABLE_LOW;
              cnt     <= '0;
              level_o <= 1'b0;
              fall_o  <= 1'b1;
            end else begin
              state <= WAIT_LOW;
              cnt   <= CNT_ONE;
            end
          end
        end

        WAIT_LOW: begin
          if (!sync) begin
            if (cnt == CNT_LAST) begin
              state   <= STABLE_LOW;
              cnt     <= '0;
              level_o <= 1'b0;
              fall_o  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            state        <= STABLE_HIGH;
            cnt          <= '0;
            glitch_cnt_o <= glitch_inc(glitch_cnt_o);
          end
        end

        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Self-checking bench for input_conditioner. Instance dut uses
// SYNC_STAGES=2 / DEBOUNCE_CYCLES=4, instance dut1 uses DEBOUNCE_CYCLES=1.
// -----------------------------------------------------------------------------
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            d_i   = 1'b0;
  logic            level_o, rise_o, fall_o;
  logic [7:0]      glitch_cnt_o;
  ic_state_t       state_o;

  logic            rst1_n = 1'b0;
  logic            d1     = 1'b1;
  logic            level1, rise1, fall1;
  logic [7:0]      glitch1;
  ic_state_t       state1;

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_i          (d_i),
    .level_o      (level_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .glitch_cnt_o (glitch_cnt_o),
    .state_o      (state_o)
  );

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst1_n),
    .d_i          (d1),
    .level_o      (level1),
    .rise_o       (rise1),
    .fall_o       (fall1),
    .glitch_cnt_o (glitch1),
    .state_o      (state1)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic       d;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] glitch;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {21'b0, level_o, rise_o, fall_o, glitch_cnt_o};
  endfunction

  function automatic logic [31:0] outs1();
    return {21'b0, level1, rise1, fall1, glitch1};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic add(input logic d, input logic l, input logic r, input logic f,
                     input logic [7:0] g);
    vec_t v;
    v.d = d; v.level = l; v.rise = r; v.fall = f; v.glitch = g;
    vecs.push_back(v);
  endtask

  // Drive d on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic d);
    @(negedge clk);
    d_i = d;
    @(posedge clk);
    #1;
  endtask

  int pulses;

  initial begin
    // ---- reset state, both instances held in reset ----
    #1;
    check("reset_outputs", outs(), 32'h0);
    check("reset_state", {30'b0, state_o}, {30'b0, STABLE_LOW});
    repeat (2) @(negedge clk);

    // ---- DEBOUNCE_CYCLES=1, d=1 at reset release: rise at edge 3 ----
    rst1_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("deb1_edge%0d", e), outs1(),
            {21'b0, (e >= 3), (e == 3), 1'b0, 8'h00});
    end

    // ---- release dut with d_i=0 and let the chain settle ----
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b0);
    check("idle_after_reset", outs(), 32'h0);

    // ---- table: rise, fall, low glitch, rise, high glitch ----
    for (int i = 1; i <= 8; i++) add(1'b1, i >= 6, i == 6, 1'b0, 8'd0);
    for (int i = 1; i <= 8; i++) add(1'b0, i < 6, 1'b0, i == 6, 8'd0);
    add(1'b1, 0, 0, 0, 8'd0);
    add(1'b1, 0, 0, 0, 8'd0);
    add(1'b0, 0, 0, 0, 8'd0);
    add(1'b0, 0, 0, 0, 8'd0);
    add(1'b0, 0, 0, 0, 8'd1);
    add(1'b0, 0, 0, 0, 8'd1);
    for (int i = 1; i <= 8; i++) add(1'b1, i >= 6, i == 6, 1'b0, 8'd1);
    add(1'b0, 1, 0, 0, 8'd1);
    for (int i = 2; i <= 6; i++) add(1'b1, 1, 0, 0, (i >= 4) ? 8'd2 : 8'd1);

    foreach (vecs[k]) exp_q.push_back({21'b0, vecs[k].level, vecs[k].rise,
                                       vecs[k].fall, vecs[k].glitch});
    foreach (vecs[k]) begin
      logic [31:0] e;
      step(vecs[k].d);
      e = exp_q.pop_front();
      check($sformatf("vec%0d", k), outs(), e);
    end
    check("state_after_table", {30'b0, state_o}, {30'b0, STABLE_HIGH});

    // ---- glitch counter saturation from the high side ----
    pulses = 0;
    for (int k = 1; k <= 300; k++) begin
      step(1'b0);
      if (rise_o || fall_o) pulses++;
      for (int j = 0; j < 3; j++) begin
        step(1'b1);
        if (rise_o || fall_o) pulses++;
      end
      if (k == 100) check("glitch_100", {24'b0, glitch_cnt_o}, 32'd102);
    end
    check("glitch_sat", {24'b0, glitch_cnt_o}, 32'd255);
    check("glitch_no_pulses", pulses, 32'd0);
    step(1'b0);
    repeat (3) step(1'b1);
    check("glitch_sat_hold", outs(), {21'b0, 1'b1, 1'b0, 1'b0, 8'hFF});

    // ---- reset asserted mid-debounce (WAIT_HIGH, count 3) ----
    @(negedge clk);
    rst_n = 1'b0;
    d_i   = 1'b0;
    #1;
    check("rst_clears", outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1'b1);
    check("wait_high_before_abort", {30'b0, state_o}, {30'b0, WAIT_HIGH});
    @(negedge clk);
    rst_n = 1'b0;
    d_i   = 1'b0;
    #1;
    check("abort_outputs", outs(), 32'h0);
    check("abort_state", {30'b0, state_o}, {30'b0, STABLE_LOW});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0);
      check($sformatf("post_abort%0d", i), outs(), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
